// File: rtl/as_imem_jtag_loader_pkg.sv
// Shared constants and types for the JTAG instruction-memory loader.
package as_imem_jtag_loader_pkg;

    localparam logic [7:0] IMEM_SCAN_IR    = 8'h80;
    localparam int         IMEM_ADDR_WIDTH = 10;
    localparam int         INSTR_WIDTH     = 32;
    localparam int         IM_SCAN_LENGTH  = IMEM_ADDR_WIDTH + INSTR_WIDTH + 1;
    localparam int         IMLD_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RWAIT = 2'd3
    } imld_state_t;

    // Instruction memory accesses must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/as_imem_jtag_loader_sync_edge.sv
// Multi-stage synchroniser: one channel with a rising-edge pulse output,
// plus a plain WIDTH-bit synchronised data path.
module as_sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             edge_i,
    output logic             edge_rise_o,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [STAGES-1:0]            edge_sync_q, edge_sync_d;
    logic                         edge_dly_q, edge_dly_d;
    logic [STAGES-1:0][WIDTH-1:0] data_sync_q, data_sync_d;

    // Shift every chain by one stage; the delayed copy feeds the edge detector.
    always_comb begin
        edge_sync_d = {edge_sync_q[STAGES-2:0], edge_i};
        edge_dly_d  = edge_sync_q[STAGES-1];
        data_sync_d = {data_sync_q[STAGES-2:0], data_i};
    end

    // Synchroniser flops, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            edge_sync_q <= '0;
            edge_dly_q  <= 1'b0;
            data_sync_q <= '0;
        end else begin
            edge_sync_q <= edge_sync_d;
            edge_dly_q  <= edge_dly_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign edge_rise_o = edge_sync_q[STAGES-1] & ~edge_dly_q;
    assign data_o      = data_sync_q[STAGES-1];

endmodule

// File: rtl/as_imem_jtag_loader.sv
// JTAG data register and access sequencer for I-Mem load/readback.
// TAP signals are oversampled in clk_i; each Update-DR becomes one I-Mem access.
module as_imem_jtag_loader
    import as_imem_jtag_loader_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_WIDTH,
    parameter int DATA_W      = INSTR_WIDTH,
    parameter int SYNC_STAGES = IMLD_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tck_i,
    input  logic              tdi_i,
    input  logic              sel_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    output logic              tdo_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              imem_we_o,
    output logic              imem_re_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int SCAN_LEN = ADDR_W + DATA_W + 1;

    logic tck_rise, tdi_s, sel_s, cap_s, shf_s, upd_s;
    logic tap_act;

    logic [SCAN_LEN-1:0] sr_q, sr_d;
    logic                tdo_q, tdo_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0]   upd_addr_q, upd_addr_d;
    logic [DATA_W-1:0]   upd_data_q, upd_data_d;
    logic                upd_we_q, upd_we_d;
    logic                start_q, start_d;
    imld_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;
    logic                we_strobe, re_strobe, misalign;

    as_sync_edge #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (5)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .edge_i      (tck_i),
        .edge_rise_o (tck_rise),
        .data_i      ({tdi_i, sel_i, capture_dr_i, shift_dr_i, update_dr_i}),
        .data_o      ({tdi_s, sel_s, cap_s, shf_s, upd_s})
    );

    // TAP actions only happen on a sampled TCK rise while the scan instruction is selected.
    assign tap_act = tck_rise & sel_s;

    // Scan register: capture > shift > update; an update arriving while busy is dropped.
    always_comb begin
        sr_d       = sr_q;
        tdo_d      = sr_q[SCAN_LEN-1];
        upd_addr_d = upd_addr_q;
        upd_data_d = upd_data_q;
        upd_we_d   = upd_we_q;
        start_d    = 1'b0;
        err_d      = err_q | misalign;
        hold_d     = sel_s | (hold_q & ((state_q != IDLE) | start_q));
        if (tap_act) begin
            if (cap_s) begin
                sr_d = {addr_q, rd_buf_q, 1'b0};
            end else if (shf_s) begin
                sr_d = {sr_q[SCAN_LEN-2:0], tdi_s};
            end else if (upd_s) begin
                if ((state_q != IDLE) || start_q) begin
                    err_d = 1'b1;
                end else begin
                    upd_addr_d = sr_q[SCAN_LEN-1 -: ADDR_W];
                    upd_data_d = sr_q[DATA_W:1];
                    upd_we_d   = sr_q[0];
                    start_d    = 1'b1;
                end
            end
        end
    end

    // Access sequencer: one strobe cycle per latched update; reads wait one cycle for data.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_buf_d  = rd_buf_q;
        misalign  = 1'b0;
        we_strobe = 1'b0;
        re_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    if (!is_word_aligned(upd_addr_q[1:0])) begin
                        misalign = 1'b1;
                    end else begin
                        addr_d = upd_addr_q;
                        if (upd_we_q) begin
                            wdata_d = upd_data_q;
                            state_d = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            WRITE: begin
                we_strobe = 1'b1;
                state_d   = IDLE;
            end
            READ: begin
                re_strobe = 1'b1;
                state_d   = RWAIT;
            end
            RWAIT: begin
                rd_buf_d = imem_rdata_i;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register for the scan path, the sequencer and the sticky/hold flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_q       <= '0;
            tdo_q      <= 1'b0;
            rd_buf_q   <= '0;
            upd_addr_q <= '0;
            upd_data_q <= '0;
            upd_we_q   <= 1'b0;
            start_q    <= 1'b0;
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            tdo_q      <= tdo_d;
            rd_buf_q   <= rd_buf_d;
            upd_addr_q <= upd_addr_d;
            upd_data_q <= upd_data_d;
            upd_we_q   <= upd_we_d;
            start_q    <= start_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    assign tdo_o        = tdo_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign imem_we_o    = we_strobe;
    assign imem_re_o    = re_strobe;
    assign cpu_hold_o   = hold_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;

endmodule
